dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single data-memory port (MemWrite / ALUResult / WriteData / ReadData) between two requesters: the pipeline memory stage (CPU) and a DMA engine issuing fixed-length bursts. It sits between the memory stage, the DMA engine and the Dmem instance.
- CPU has priority.
- A wait counter bounds DMA starvation.
- Read data is returned through a registered response path.
- Out-of-range writes are blocked and flagged.

## Interface
- MAX_WAIT, 8: cycles a pending DMA request may be denied before it is force-granted (≥1).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- CpuReq, CpuWrite  in  1 each  CPU access request, write enable.
- CpuAddr, CpuWData  in  32 each  CPU byte address, write data.
- CpuStall  out  1  CpuReq & ~CpuGnt (combinational).
- CpuRData  out  32  registered read data.
- CpuRValid  out  1  read response valid.
- DmaReq, DmaWrite  in  1 each  burst request, direction.
- DmaAddr  in  32  burst start address.
- DmaLen  in  4  beats−1 (burst is 1..16 beats).
- DmaWData  in  32  per-beat write data.
- DmaGnt  out  1  current beat accepted this cycle.
- DmaRData  out  32  registered read data.
- DmaRValid  out  1  read response valid.
- DmaDone  out  1  one-cycle pulse after the last beat.
- MemWrite  out  1  to Dmem.
- ALUResult, WriteData  out  32 each  to Dmem address / data.
- ReadData  in  32  from Dmem (combinational read).
- AddrErr  out  1  sticky; cleared only by reset.

## Operation
- FSM states: IDLE, DMA_BURST. Reset → IDLE.
- **IDLE, CPU grant.** CPU is granted if CpuReq & ~force, where force = DmaReq & (WaitCnt == MAX_WAIT).
- **IDLE, DMA grant.** DMA is granted beat 0 if DmaReq & (~CpuReq | force). On this grant:
  - BeatAddr ← DmaAddr+4, BeatCnt ← DmaLen, BurstWrite ← DmaWrite.
  - Go to DMA_BURST if DmaLen≠0; otherwise stay in IDLE and pulse DmaDone next cycle.
- **DMA_BURST.** DMA owns the port; CpuStall = CpuReq.
  - Each cycle with DmaReq high: DmaGnt=1, address = BeatAddr, BeatAddr += 4, BeatCnt −= 1.
  - On the beat with BeatCnt==1: go to IDLE and pulse DmaDone next cycle.
  - DmaReq low in DMA_BURST = abort: no grant, go to IDLE, no DmaDone.
  - DmaWrite and DmaAddr are ignored after beat 0.
- **WaitCnt** (clog2(MAX_WAIT+1) bits):
  - +1 each cycle DmaReq is high and DmaGnt is low, saturating at MAX_WAIT.
  - Cleared on any DMA grant or when DmaReq is low.
  - Forced grant preempts the CPU for beat 0 and the whole burst.
- **Port mux.** ALUResult/WriteData come from the granted requester; both are 0 when nobody is granted.
  - MemWrite = granted & write & inRange, where inRange = (addr[31:23]==0).
  - Any granted write with ~inRange sets AddrErr; that access is otherwise completed and still granted.
- **Read responses.** A granted read captures ReadData into the requester's RData register at the clock edge. RValid is high the following cycle only.
  - RData holds its value until the next read.
- **Address bits.** addr[1:0] are passed through unchanged; Dmem word-aligns.

## Timing
- Write: committed at the edge ending the grant cycle (0-cycle latency to memory).
- Read: RValid/RData one cycle after the grant cycle.
- A burst of N beats with DmaReq held occupies exactly N consecutive cycles, then the CPU is served on the next cycle if CpuReq is high.
- Requester handshake: hold Req and fields stable until granted. Once per-beat write data is granted, DmaWData must advance the next cycle.
- Simultaneous CpuReq & DmaReq with WaitCnt<MAX_WAIT: CPU wins and WaitCnt increments.
- Address wrap: BeatAddr is a 32-bit increment with no wrap guard; crossing 0x007F_FFFC→0x0080_0000 leaves the range and triggers AddrErr.
- Reset mid-burst: next cycle the FSM is in IDLE, and counters and outputs are at reset values. No pending write is issued.
- Reset values: CpuStall follows CpuReq; DmaGnt=0, MemWrite=0, RValids=0, RDatas=0, DmaDone=0, AddrErr=0, ALUResult=WriteData=0.

## Test plan
- **CPU only.** CPU write 0x1234_5678 to 0x100, then read 0x100 → MemWrite high one cycle; CpuRValid one cycle after the read grant with CpuRData=0x1234_5678; CpuStall stays 0.
- **Burst write.** DMA burst write DmaLen=3 at 0x200 (data A,B,C,D) with the CPU idle → DmaGnt for 4 consecutive cycles at addresses 0x200..0x20C, then DmaDone pulse. Read-back matches.
- **Starvation.** CpuReq held continuously with DmaReq high, MAX_WAIT=8 → DMA denied 8 cycles, granted on the 9th; CpuStall high for the full burst; WaitCnt returns to 0.
- **Abort.** DmaReq dropped after 2 of 5 beats → FSM back in IDLE; no DmaDone; a CPU request on the next cycle is granted.
- **Out-of-range write.** DMA write burst DmaLen=1 starting 0x007F_FFFC → first beat written, second beat MemWrite=0 and AddrErr=1, sticky until reset.
- **Reset mid-burst.** Reset asserted during beat 2 of a burst → next cycle all outputs at reset values, FSM IDLE, no further writes.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the pipeline memory stage (CPU)
// and a DMA engine that issues fixed-length bursts. The CPU normally wins.
// A saturating wait counter force-grants a DMA request that has been denied
// for MAX_WAIT cycles, and that forced grant holds for the whole burst.
// Reads return through registered per-requester response paths. Writes whose
// address falls outside the Dmem window are suppressed and flagged.
//
// Parameters
//   MAX_WAIT   cycles a pending DMA request may be denied before it is forced
//              (must be >= 1)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   CpuReq/CpuWrite            CPU request / write enable
//   CpuAddr/CpuWData           CPU byte address / write data
//   CpuStall                   CpuReq & ~CPU grant (combinational)
//   CpuRData/CpuRValid         registered CPU read response
//   DmaReq/DmaWrite            DMA burst request / direction (sampled on beat 0)
//   DmaAddr/DmaLen             burst start address / beats-1 (sampled on beat 0)
//   DmaWData                   per-beat DMA write data
//   DmaGnt                     current DMA beat accepted this cycle
//   DmaRData/DmaRValid         registered DMA read response
//   DmaDone                    one-cycle pulse after the last beat of a burst
//   MemWrite/ALUResult/WriteData  Dmem write enable / address / write data
//   ReadData                   Dmem combinational read data
//   AddrErr                    sticky out-of-range write flag
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        CpuReq,
    input  logic        CpuWrite,
    input  logic [31:0] CpuAddr,
    input  logic [31:0] CpuWData,
    output logic        CpuStall,
    output logic [31:0] CpuRData,
    output logic        CpuRValid,

    input  logic        DmaReq,
    input  logic        DmaWrite,
    input  logic [31:0] DmaAddr,
    input  logic [3:0]  DmaLen,
    input  logic [31:0] DmaWData,
    output logic        DmaGnt,
    output logic [31:0] DmaRData,
    output logic        DmaRValid,
    output logic        DmaDone,

    output logic        MemWrite,
    output logic [31:0] ALUResult,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData,

    output logic        AddrErr
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    // Response channel indices for the generate loop below.
    localparam int CH_CPU = 0;
    localparam int CH_DMA = 1;

    typedef enum logic {
        IDLE,
        DMA_BURST
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        beat_addr_reg, beat_addr_next;
    logic [3:0]         beat_cnt_reg, beat_cnt_next;
    logic               burst_write_reg, burst_write_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic               done_reg, done_next;
    logic               addr_err_reg, addr_err_next;

    logic               force_grant;
    logic               cpu_gnt;
    logic               dma_gnt;
    logic               dma_write_eff;
    logic [31:0]        dma_addr_eff;

    logic               gnt_any;
    logic               gnt_write;
    logic [31:0]        gnt_addr;
    logic [31:0]        gnt_wdata;
    logic               in_range;

    logic               rd_gnt     [0:1];
    logic [31:0]        rdata_reg  [0:1];
    logic               rvalid_reg [0:1];

    // A DMA request that has waited the full budget takes the port even if
    // the CPU is asking for it.
    assign force_grant = DmaReq && (wait_cnt_reg == WAIT_LIMIT);

    // -------------------------------------------------------------------------
    // Arbitration FSM: next state, grants and burst bookkeeping.
    // Grants are withheld while reset is asserted so that a burst interrupted
    // by reset cannot push one more write into Dmem on the reset cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        beat_addr_next   = beat_addr_reg;
        beat_cnt_next    = beat_cnt_reg;
        burst_write_next = burst_write_reg;
        done_next        = 1'b0;
        cpu_gnt          = 1'b0;
        dma_gnt          = 1'b0;
        dma_write_eff    = burst_write_reg;
        dma_addr_eff     = beat_addr_reg;

        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    // Beat 0 is driven straight from the request fields.
                    dma_write_eff = DmaWrite;
                    dma_addr_eff  = DmaAddr;
                    cpu_gnt       = CpuReq && !force_grant;
                    dma_gnt       = DmaReq && (!CpuReq || force_grant);
                    if (dma_gnt) begin
                        beat_addr_next   = DmaAddr + 32'd4;
                        beat_cnt_next    = DmaLen;
                        burst_write_next = DmaWrite;
                        if (DmaLen != 4'd0) begin
                            state_next = DMA_BURST;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end

                DMA_BURST: begin
                    if (DmaReq) begin
                        dma_gnt        = 1'b1;
                        beat_addr_next = beat_addr_reg + 32'd4;
                        beat_cnt_next  = beat_cnt_reg - 4'd1;
                        if (beat_cnt_reg == 4'd1) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        // Requester dropped mid-burst: abandon it silently.
                        state_next = IDLE;
                    end
                end

                default: state_next = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Starvation counter: counts denied DMA cycles, saturates at the limit,
    // and clears whenever the DMA is served or stops asking.
    // -------------------------------------------------------------------------
    always_comb begin
        wait_cnt_next = '0;
        if (DmaReq && !dma_gnt) begin
            if (wait_cnt_reg == WAIT_LIMIT) begin
                wait_cnt_next = wait_cnt_reg;
            end else begin
                wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Memory port mux. Idle port drives zeros so Dmem sees a quiet bus.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_any   = cpu_gnt || dma_gnt;
        gnt_write = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        if (cpu_gnt) begin
            gnt_write = CpuWrite;
            gnt_addr  = CpuAddr;
            gnt_wdata = CpuWData;
        end else if (dma_gnt) begin
            gnt_write = dma_write_eff;
            gnt_addr  = dma_addr_eff;
            gnt_wdata = DmaWData;
        end
    end

    // Dmem covers the low 8 MiB; anything above is not backed by memory.
    assign in_range      = (gnt_addr[31:23] == 9'd0);
    assign addr_err_next = addr_err_reg || (gnt_any && gnt_write && !in_range);

    assign MemWrite  = gnt_any && gnt_write && in_range;
    assign ALUResult = gnt_addr;
    assign WriteData = gnt_wdata;
    assign CpuStall  = CpuReq && !cpu_gnt;
    assign DmaGnt    = dma_gnt;
    assign DmaDone   = done_reg;
    assign AddrErr   = addr_err_reg;

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            beat_addr_reg   <= '0;
            beat_cnt_reg    <= '0;
            burst_write_reg <= 1'b0;
            wait_cnt_reg    <= '0;
            done_reg        <= 1'b0;
            addr_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            beat_addr_reg   <= beat_addr_next;
            beat_cnt_reg    <= beat_cnt_next;
            burst_write_reg <= burst_write_next;
            wait_cnt_reg    <= wait_cnt_next;
            done_reg        <= done_next;
            addr_err_reg    <= addr_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Registered read responses, one identical channel per requester.
    // RData keeps the last read value; RValid is a single-cycle strobe.
    // -------------------------------------------------------------------------
    assign rd_gnt[CH_CPU] = cpu_gnt && !CpuWrite;
    assign rd_gnt[CH_DMA] = dma_gnt && !dma_write_eff;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else begin
                    rvalid_reg[gi] <= rd_gnt[gi];
                    if (rd_gnt[gi]) begin
                        rdata_reg[gi] <= ReadData;
                    end
                end
            end
        end
    endgenerate

    assign CpuRData  = rdata_reg[CH_CPU];
    assign CpuRValid = rvalid_reg[CH_CPU];
    assign DmaRData  = rdata_reg[CH_DMA];
    assign DmaRValid = rvalid_reg[CH_DMA];

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a small word-addressed Dmem model.
// Stimulus pushes expected events (memory writes, DMA grants, read responses,
// DmaDone pulses), each tagged with the cycle it must appear in, into queues.
// A monitor running on the falling edge pops and compares whenever the DUT
// shows one of those events. Level checks (stall, error flag, reset values)
// are made directly by the stimulus on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        CpuReq, CpuWrite;
    logic [31:0] CpuAddr, CpuWData;
    logic        CpuStall;
    logic [31:0] CpuRData;
    logic        CpuRValid;
    logic        DmaReq, DmaWrite;
    logic [31:0] DmaAddr;
    logic [3:0]  DmaLen;
    logic [31:0] DmaWData;
    logic        DmaGnt;
    logic [31:0] DmaRData;
    logic        DmaRValid;
    logic        DmaDone;
    logic        MemWrite;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        AddrErr;

    int cyc = 0;
    int checks = 0;
    int fails = 0;

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t wr_q[$];
    exp_t gnt_q[$];
    exp_t crd_q[$];
    exp_t drd_q[$];
    exp_t done_q[$];

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .CpuReq    (CpuReq),
        .CpuWrite  (CpuWrite),
        .CpuAddr   (CpuAddr),
        .CpuWData  (CpuWData),
        .CpuStall  (CpuStall),
        .CpuRData  (CpuRData),
        .CpuRValid (CpuRValid),
        .DmaReq    (DmaReq),
        .DmaWrite  (DmaWrite),
        .DmaAddr   (DmaAddr),
        .DmaLen    (DmaLen),
        .DmaWData  (DmaWData),
        .DmaGnt    (DmaGnt),
        .DmaRData  (DmaRData),
        .DmaRValid (DmaRValid),
        .DmaDone   (DmaDone),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .AddrErr   (AddrErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Dmem model: 1024 words, combinational read, write on the clock edge.
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end
    always @(posedge clk) if (MemWrite) mem[ALUResult[11:2]] <= WriteData;
    assign ReadData = mem[ALUResult[11:2]];

    function automatic exp_t mk(input int c, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.c = c;
        e.a = a;
        e.d = d;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
        end
    endtask

    task automatic cmp_evt(input string nm, input bit empty, input exp_t e,
                           input logic [31:0] a, input logic [31:0] d);
        checks++;
        if (empty) begin
            fails++;
            $display("FAIL %s: unexpected event at cycle %0d (addr %h data %h)", nm, cyc, a, d);
        end else if (e.c != cyc || e.a !== a || e.d !== d) begin
            fails++;
            $display("FAIL %s: got cycle %0d addr %h data %h, expected cycle %0d addr %h data %h",
                     nm, cyc, a, d, e.c, e.a, e.d);
        end
    endtask

    // Monitor: every event the DUT presents must match the head of its queue.
    exp_t m_e;
    bit   m_em;
    always @(negedge clk) begin
        if (MemWrite) begin
            m_em = (wr_q.size() == 0);
            m_e  = m_em ? mk(0, 0, 0) : wr_q.pop_front();
            cmp_evt("mem_write", m_em, m_e, ALUResult, WriteData);
        end
        if (DmaGnt) begin
            m_em = (gnt_q.size() == 0);
            m_e  = m_em ? mk(0, 0, 0) : gnt_q.pop_front();
            cmp_evt("dma_gnt", m_em, m_e, ALUResult, 32'h0);
        end
        if (CpuRValid) begin
            m_em = (crd_q.size() == 0);
            m_e  = m_em ? mk(0, 0, 0) : crd_q.pop_front();
            cmp_evt("cpu_rdata", m_em, m_e, 32'h0, CpuRData);
        end
        if (DmaRValid) begin
            m_em = (drd_q.size() == 0);
            m_e  = m_em ? mk(0, 0, 0) : drd_q.pop_front();
            cmp_evt("dma_rdata", m_em, m_e, 32'h0, DmaRData);
        end
        if (DmaDone) begin
            m_em = (done_q.size() == 0);
            m_e  = m_em ? mk(0, 0, 0) : done_q.pop_front();
            cmp_evt("dma_done", m_em, m_e, 32'h0, 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        CpuReq = 0; CpuWrite = 0; CpuAddr = 0; CpuWData = 0;
        DmaReq = 0; DmaWrite = 0; DmaAddr = 0; DmaLen = 0; DmaWData = 0;
    endtask

    task automatic cpu_rd(input logic [31:0] addr, input logic [31:0] exp);
        CpuReq = 1; CpuWrite = 0; CpuAddr = addr;
        crd_q.push_back(mk(cyc + 1, 32'h0, exp));
    endtask

    task automatic dma_beat(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] wdata);
        DmaReq = 1; DmaWrite = wr; DmaAddr = addr; DmaLen = len; DmaWData = wdata;
    endtask

    task automatic end_q(input string nm, input int n);
        checks++;
        if (n != 0) begin
            fails++;
            $display("FAIL %s: %0d expected events never seen, expected 0 left", nm, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bd [0:3];
        bd[0] = 32'hAAAA_0000; bd[1] = 32'hBBBB_0001;
        bd[2] = 32'hCCCC_0002; bd[3] = 32'hDDDD_0003;

        // ---------------- reset values ----------------
        idle_in();
        CpuReq = 1;
        reset  = 1;
        step(); step();
        @(negedge clk);
        chk("rst_cpustall",  CpuStall,  1);
        chk("rst_dmagnt",    DmaGnt,    0);
        chk("rst_memwrite",  MemWrite,  0);
        chk("rst_aluresult", ALUResult, 0);
        chk("rst_writedata", WriteData, 0);
        chk("rst_cpurvalid", CpuRValid, 0);
        chk("rst_dmarvalid", DmaRValid, 0);
        chk("rst_cpurdata",  CpuRData,  0);
        chk("rst_dmardata",  DmaRData,  0);
        chk("rst_dmadone",   DmaDone,   0);
        chk("rst_addrerr",   AddrErr,   0);
        step();
        reset = 0;
        idle_in();

        // ---------------- CPU only ----------------
        step();
        CpuReq = 1; CpuWrite = 1; CpuAddr = 32'h100; CpuWData = 32'h1234_5678;
        wr_q.push_back(mk(cyc, 32'h100, 32'h1234_5678));
        @(negedge clk); chk("cpu_wr_stall", CpuStall, 0);
        step();
        cpu_rd(32'h100, 32'h1234_5678);
        @(negedge clk); chk("cpu_rd_stall", CpuStall, 0);
        step(); idle_in();

        // ---------------- burst write, 4 beats at 0x200 ----------------
        // Direction and start address are changed after beat 0 on purpose:
        // the burst must keep the values captured on its first beat.
        for (int i = 0; i < 4; i++) begin
            step();
            dma_beat((i == 0) ? 1'b1 : 1'b0, (i == 0) ? 32'h200 : 32'h0F00, 4'd3, bd[i]);
            gnt_q.push_back(mk(cyc, 32'h200 + 32'(4 * i), 32'h0));
            wr_q.push_back(mk(cyc, 32'h200 + 32'(4 * i), bd[i]));
            if (i == 3) done_q.push_back(mk(cyc + 1, 32'h0, 32'h0));
        end
        step(); idle_in();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            cpu_rd(32'h200 + 32'(4 * i), bd[i]);
        end
        step(); idle_in();

        // ---------------- burst read, 2 beats at 0x208 ----------------
        for (int i = 0; i < 2; i++) begin
            step();
            dma_beat(1'b0, 32'h208, 4'd1, 32'h0);
            gnt_q.push_back(mk(cyc, 32'h208 + 32'(4 * i), 32'h0));
            drd_q.push_back(mk(cyc + 1, 32'h0, bd[2 + i]));
            if (i == 1) done_q.push_back(mk(cyc + 1, 32'h0, 32'h0));
        end
        step(); idle_in();

        // ---------------- starvation ----------------
        // CPU reads continuously; the DMA is denied MAX_WAIT cycles, then
        // takes both beats of its burst while the CPU stalls.
        for (int k = 0; k < 12; k++) begin
            step();
            cpu_rd_hold: begin
                CpuReq = 1; CpuWrite = 0; CpuAddr = 32'h100;
            end
            if (k < 10 || k == 11) begin
                dma_beat(1'b1, 32'h300, 4'd1, (k == 9) ? 32'h0000_F00F : 32'h0000_E00E);
            end else begin
                DmaReq = 0;
            end
            if (k < MAX_WAIT || k >= 10) begin
                crd_q.push_back(mk(cyc + 1, 32'h0, 32'h1234_5678));
                @(negedge clk); chk($sformatf("starve_stall_%0d", k), CpuStall, 0);
            end else if (k == MAX_WAIT) begin
                gnt_q.push_back(mk(cyc, 32'h300, 32'h0));
                wr_q.push_back(mk(cyc, 32'h300, 32'h0000_E00E));
                @(negedge clk); chk($sformatf("starve_stall_%0d", k), CpuStall, 1);
            end else begin
                gnt_q.push_back(mk(cyc, 32'h304, 32'h0));
                wr_q.push_back(mk(cyc, 32'h304, 32'h0000_F00F));
                done_q.push_back(mk(cyc + 1, 32'h0, 32'h0));
                @(negedge clk); chk($sformatf("starve_stall_%0d", k), CpuStall, 1);
            end
        end
        step(); idle_in();
        cpu_rd(32'h304, 32'h0000_F00F);
        step(); idle_in();

        // ---------------- abort after 2 of 5 beats ----------------
        for (int i = 0; i < 2; i++) begin
            step();
            dma_beat(1'b1, 32'h400, 4'd4, 32'h4000_0000 + 32'(i));
            gnt_q.push_back(mk(cyc, 32'h400 + 32'(4 * i), 32'h0));
            wr_q.push_back(mk(cyc, 32'h400 + 32'(4 * i), 32'h4000_0000 + 32'(i)));
        end
        step();
        DmaReq = 0;
        CpuReq = 1; CpuWrite = 0; CpuAddr = 32'h404;
        @(negedge clk); chk("abort_cycle_stall", CpuStall, 1);
        step();
        cpu_rd(32'h404, 32'h4000_0001);
        @(negedge clk); chk("abort_cpu_granted", CpuStall, 0);
        step(); idle_in();
        step();

        // ---------------- out-of-range write ----------------
        step();
        dma_beat(1'b1, 32'h007F_FFFC, 4'd1, 32'h7777_0000);
        gnt_q.push_back(mk(cyc, 32'h007F_FFFC, 32'h0));
        wr_q.push_back(mk(cyc, 32'h007F_FFFC, 32'h7777_0000));
        @(negedge clk); chk("oor_err_before", AddrErr, 0);
        step();
        DmaWData = 32'h8888_0000;
        gnt_q.push_back(mk(cyc, 32'h0080_0000, 32'h0));
        done_q.push_back(mk(cyc + 1, 32'h0, 32'h0));
        @(negedge clk);
        chk("oor_memwrite", MemWrite, 0);
        chk("oor_err_same_cycle", AddrErr, 0);
        step(); idle_in();
        cpu_rd(32'h007F_FFFC, 32'h7777_0000);
        @(negedge clk); chk("oor_err_set", AddrErr, 1);
        step(); idle_in();
        cpu_rd(32'h0, 32'h0);
        step(); idle_in();
        step();
        @(negedge clk); chk("oor_err_sticky", AddrErr, 1);

        // ---------------- reset mid-burst ----------------
        for (int i = 0; i < 2; i++) begin
            step();
            dma_beat(1'b1, 32'h500, 4'd3, 32'h5000_0000 + 32'(i));
            gnt_q.push_back(mk(cyc, 32'h500 + 32'(4 * i), 32'h0));
            wr_q.push_back(mk(cyc, 32'h500 + 32'(4 * i), 32'h5000_0000 + 32'(i)));
        end
        step();
        reset = 1;
        DmaWData = 32'h5000_0002;
        @(negedge clk);
        chk("rst_burst_dmagnt", DmaGnt, 0);
        chk("rst_burst_memwrite", MemWrite, 0);
        step();
        reset = 0;
        idle_in();
        @(negedge clk);
        chk("post_rst_addrerr", AddrErr, 0);
        chk("post_rst_dmadone", DmaDone, 0);
        chk("post_rst_dmagnt", DmaGnt, 0);
        chk("post_rst_aluresult", ALUResult, 0);
        chk("post_rst_cpurvalid", CpuRValid, 0);
        step();
        cpu_rd(32'h500, 32'h5000_0000);
        @(negedge clk); chk("post_rst_idle_stall", CpuStall, 0);
        step();
        cpu_rd(32'h508, 32'h0);
        step(); idle_in();
        step(); step();

        end_q("wr_q", wr_q.size());
        end_q("gnt_q", gnt_q.size());
        end_q("crd_q", crd_q.size());
        end_q("drd_q", drd_q.size());
        end_q("done_q", done_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
